uart_mmio: RTL

- Memory-mapped serial port on the CPU data bus (ram2_* signals), beside the SRAM bridge, which routes UART-window accesses here.
- Owns txd/rxd directly: 8N1 transmitter, 8N1 receiver with 2-flop synchroniser, and a small RX FIFO.
- The CPU polls a status word and reads or writes a data word.

---
 rtl/uart_mmio.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: polled status word, data word, transmitter and receiver with a small RX FIFO.
// The CPU bus accesses are single-cycle; txd/rxd are owned directly by this block.
module uart_mmio #(
    parameter int          CLK_FREQ   = 10000000,
    parameter int          BAUD       = 9600,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] DATA_ADDR  = 32'hBFD003F8,
    parameter logic [31:0] STAT_ADDR  = 32'hBFD003FC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    output logic        txd,
    input  logic        rxd
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = (DIV / 2 > 0) ? DIV / 2 : 1;
    localparam int CW   = $clog2(DIV + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);
    localparam logic [PW:0]   CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]   CNT_FULL  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    uart_state_t tx_state, rx_state;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_bit, rx_bit;
    logic [7:0]    tx_shreg, rx_shreg;
    logic          rx_meta, rxs;
    logic          tx_drop, rx_ovf, frame_err;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   fifo_count;

    logic data_sel, stat_sel, data_rd, stat_rd, data_wr;
    logic tx_ready, tx_accept, tx_drop_set;
    logic rx_avail, fifo_full, pop, push, push_req, ovf_set, frame_set, rx_stop_tick;
    logic unused_bits;

    assign unused_bits = &{1'b0, sel_i[3:1], data_i[31:8]};

    assign data_sel = ce_i && (addr_i == DATA_ADDR);
    assign stat_sel = ce_i && (addr_i == STAT_ADDR);
    assign hit_o    = data_sel || stat_sel;
    assign data_rd  = data_sel && !we_i;
    assign stat_rd  = stat_sel && !we_i;
    assign data_wr  = data_sel && we_i && sel_i[0];

    assign tx_ready    = (tx_state == S_IDLE);
    assign tx_accept   = data_wr && tx_ready;
    assign tx_drop_set = data_wr && !tx_ready;

    assign rx_avail     = (fifo_count != '0);
    assign fifo_full    = (fifo_count == CNT_FULL);
    assign pop          = data_rd && rx_avail;
    assign rx_stop_tick = (rx_state == S_STOP) && (rx_cnt == DIV_LAST);
    assign push_req     = rx_stop_tick && rxs;
    assign frame_set    = rx_stop_tick && !rxs;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push         = push_req && (!fifo_full || pop);
    assign ovf_set      = push_req && fifo_full && !pop;

    always_comb begin
        data_o = '0;
        if (data_rd && rx_avail)
            data_o = {24'b0, fifo_mem[rd_ptr]};
        else if (stat_rd)
            data_o = {27'b0, frame_err, rx_ovf, tx_drop, rx_avail, tx_ready};
    end

    // txd is registered from the state, so it lags state entry by one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shreg <= '0;
            txd      <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    txd <= 1'b1;
                    if (tx_accept) begin
                        tx_shreg <= data_i[7:0];
                        tx_cnt   <= '0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    txd <= 1'b0;
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    txd <= tx_shreg[0];
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx_shreg <= {1'b0, tx_shreg[7:1]};
                        if (tx_bit == 3'd7) tx_state <= S_STOP;
                        else                tx_bit   <= tx_bit + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    txd <= 1'b1;
                    if (tx_cnt == DIV_LAST) begin
                        tx_cnt   <= '0;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + BAUD_ONE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta  <= 1'b1;
            rxs      <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shreg <= '0;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            case (rx_state)
                S_IDLE: begin
                    if (!rxs) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + BAUD_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shreg <= {rxs, rx_shreg[7:1]};
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + BAUD_ONE;
                    end
                end
                S_STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + BAUD_ONE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rx_shreg;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      fifo_count <= fifo_count + CNT_ONE;
            else if (pop && !push) fifo_count <= fifo_count - CNT_ONE;
        end
    end

    // Sticky flags: a set event in the same cycle as a STAT read wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_drop   <= 1'b0;
            rx_ovf    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            tx_drop   <= tx_drop_set || (tx_drop && !stat_rd);
            rx_ovf    <= ovf_set     || (rx_ovf && !stat_rd);
            frame_err <= frame_set   || (frame_err && !stat_rd);
        end
    end

endmodule
